// File: rtl/control_entrada_cronometro_if.sv
// Scan-byte input and store-command output bundle
// for the chronometer keyboard-entry controller.
interface control_entrada_cronometro_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [7:0] dato1;
    logic [7:0] dato2;
    logic [7:0] dato3;
    logic [7:0] tecla;
    logic [7:0] guardar;
    logic [1:0] digit_count;
    logic       entry_active;

    modport master (
        output scan_code, scan_valid,
        input  dato1, dato2, dato3, tecla, guardar,
        input  digit_count, entry_active
    );

    modport slave (
        input  scan_code, scan_valid,
        output dato1, dato2, dato3, tecla, guardar,
        output digit_count, entry_active
    );
endinterface

// File: rtl/control_entrada_cronometro.sv
// Keyboard entry of a 3-digit limit from PS/2 set-2
// make codes, emitting a one-cycle store command.
module control_entrada_cronometro #(
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned TO_W           = 29
) (
    input  logic clk,
    input  logic reset,
    control_entrada_cronometro_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic [7:0] K_E0   = 8'hE0;
    localparam logic [7:0] K_F0   = 8'hF0;
    localparam logic [7:0] K_BKSP = 8'h66;
    localparam logic [7:0] K_ESC  = 8'h76;
    localparam logic [7:0] K_SAVE = 8'h75;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      tecla_q, tecla_d;
    logic [7:0]      guar_q, guar_d;
    logic            brk_q, brk_d;
    logic [7:0]      last_q, last_d;
    logic [TO_W-1:0] to_q, to_d;

    logic            accepted;
    logic            is_digit;
    logic [3:0]      digit;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (bus.scan_code)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        d3_d     = d3_q;
        cnt_d    = cnt_q;
        tecla_d  = 8'h00;
        guar_d   = 8'h00;
        brk_d    = brk_q;
        last_d   = last_q;
        to_d     = to_q;
        accepted = 1'b0;

        // COMMIT and CLEAR drop incoming bytes entirely
        if (bus.scan_valid &&
            (state_q == IDLE || state_q == ENTRY)) begin
            if (bus.scan_code == K_E0) begin
                brk_d = brk_q;
            end else if (bus.scan_code == K_F0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d  = 1'b0;
                last_d = 8'h00;
            end else if (bus.scan_code != last_q) begin
                accepted = 1'b1;
                last_d   = bus.scan_code;
            end
        end

        case (state_q)
            IDLE: begin
                to_d = '0;
                if (accepted && is_digit) begin
                    d1_d    = 4'd0;
                    d2_d    = 4'd0;
                    d3_d    = digit;
                    cnt_d   = 2'd1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (bus.scan_valid) begin
                    to_d = '0;
                    if (accepted) begin
                        if (is_digit) begin
                            if (cnt_q != 2'd3) begin
                                d1_d  = d2_q;
                                d2_d  = d3_q;
                                d3_d  = digit;
                                cnt_d = cnt_q + 2'd1;
                            end
                        end else if (bus.scan_code == K_BKSP) begin
                            d3_d  = d2_q;
                            d2_d  = d1_q;
                            d1_d  = 4'd0;
                            cnt_d = cnt_q - 2'd1;
                            if (cnt_q == 2'd1) state_d = IDLE;
                        end else if (bus.scan_code == K_ESC) begin
                            d1_d    = 4'd0;
                            d2_d    = 4'd0;
                            d3_d    = 4'd0;
                            cnt_d   = 2'd0;
                            state_d = IDLE;
                        end else if (bus.scan_code == K_SAVE &&
                                     cnt_q != 2'd0) begin
                            tecla_d = K_SAVE;
                            guar_d  = 8'h01;
                            state_d = COMMIT;
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    d1_d    = 4'd0;
                    d2_d    = 4'd0;
                    d3_d    = 4'd0;
                    cnt_d   = 2'd0;
                    to_d    = '0;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            COMMIT: begin
                d1_d    = 4'd0;
                d2_d    = 4'd0;
                d3_d    = 4'd0;
                cnt_d   = 2'd0;
                to_d    = '0;
                state_d = CLEAR;
            end
            CLEAR: begin
                d1_d    = 4'd0;
                d2_d    = 4'd0;
                d3_d    = 4'd0;
                cnt_d   = 2'd0;
                to_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            d3_q    <= 4'd0;
            cnt_q   <= 2'd0;
            tecla_q <= 8'h00;
            guar_q  <= 8'h00;
            brk_q   <= 1'b0;
            last_q  <= 8'h00;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            cnt_q   <= cnt_d;
            tecla_q <= tecla_d;
            guar_q  <= guar_d;
            brk_q   <= brk_d;
            last_q  <= last_d;
            to_q    <= to_d;
        end
    end

    assign bus.dato1        = {4'h0, d1_q};
    assign bus.dato2        = {4'h0, d2_q};
    assign bus.dato3        = {4'h0, d3_q};
    assign bus.tecla        = tecla_q;
    assign bus.guardar      = guar_q;
    assign bus.digit_count  = cnt_q;
    assign bus.entry_active = (state_q == ENTRY);
endmodule

// File: tb/tb_control_entrada_cronometro.sv
// Directed bench for the keyboard-entry controller,
// with a short timeout to exercise the abort path.
module tb_control_entrada_cronometro;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   p0;

    control_entrada_cronometro_if bus ();

    control_entrada_cronometro #(
        .TIMEOUT_CYCLES(20),
        .TO_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.tecla == 8'h75) pulses++;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    // drive at a falling edge, hold one cycle, return
    // at the falling edge after the capturing edge
    task automatic send(input logic [7:0] b);
        bus.scan_code  = b;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
    endtask

    task automatic chk_all(input string tag,
                           input logic [7:0] d1,
                           input logic [7:0] d2,
                           input logic [7:0] d3,
                           input logic [1:0] c,
                           input logic       ea);
        chk({tag, ".dato1"}, {8'h0, bus.dato1}, {8'h0, d1});
        chk({tag, ".dato2"}, {8'h0, bus.dato2}, {8'h0, d2});
        chk({tag, ".dato3"}, {8'h0, bus.dato3}, {8'h0, d3});
        chk({tag, ".count"}, {14'h0, bus.digit_count},
            {14'h0, c});
        chk({tag, ".active"}, {15'h0, bus.entry_active},
            {15'h0, ea});
    endtask

    initial begin
        bus.scan_code  = 8'h00;
        bus.scan_valid = 1'b0;
        @(negedge clk);
        send(8'h16);
        send(8'h75);
        chk_all("rst", 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
        chk("rst.tecla", {8'h0, bus.tecla}, 16'h0);
        chk("rst.guardar", {8'h0, bus.guardar}, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk_all("post_rst", 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);

        send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        send(8'h26); send(8'hF0); send(8'h26);
        chk_all("entry", 8'h1, 8'h2, 8'h3, 2'd3, 1'b1);
        p0 = pulses;
        send(8'h75);
        chk_all("commit", 8'h1, 8'h2, 8'h3, 2'd3, 1'b0);
        chk("commit.tecla", {8'h0, bus.tecla}, 16'h75);
        chk("commit.guardar", {8'h0, bus.guardar}, 16'h01);
        @(negedge clk);
        chk_all("clear", 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
        chk("clear.tecla", {8'h0, bus.tecla}, 16'h0);
        repeat (3) @(negedge clk);
        chk("one_pulse", 16'(pulses - p0), 16'd1);

        send(8'h16); send(8'h16); send(8'h16);
        chk_all("repeat", 8'h0, 8'h0, 8'h1, 2'd1, 1'b1);
        send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E);
        send(8'h26); send(8'hF0); send(8'h26);
        send(8'h2E);
        chk_all("overflow", 8'h1, 8'h2, 8'h3, 2'd3, 1'b1);

        send(8'h76);
        chk_all("esc1", 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
        send(8'h25); send(8'hF0); send(8'h25);
        send(8'h2E);
        chk_all("enter45", 8'h0, 8'h4, 8'h5, 2'd2, 1'b1);
        send(8'h66);
        chk_all("bksp", 8'h0, 8'h0, 8'h4, 2'd1, 1'b1);
        send(8'h76);
        chk_all("esc2", 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
        p0 = pulses;
        send(8'h75);
        repeat (3) @(negedge clk);
        chk("idle_save", 16'(pulses - p0), 16'd0);
        chk("idle_save.guardar", {8'h0, bus.guardar}, 16'h0);

        p0 = pulses;
        send(8'h3D);
        repeat (19) @(negedge clk);
        chk_all("to_pre", 8'h0, 8'h0, 8'h7, 2'd1, 1'b1);
        send(8'hE0);
        chk_all("to_restart", 8'h0, 8'h0, 8'h7, 2'd1, 1'b1);
        repeat (19) @(negedge clk);
        chk_all("to_edge", 8'h0, 8'h0, 8'h7, 2'd1, 1'b1);
        @(negedge clk);
        chk_all("to_abort", 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
        chk("to_nocommit", 16'(pulses - p0), 16'd0);

        send(8'h16);
        send(8'h75);
        chk("rc.tecla", {8'h0, bus.tecla}, 16'h75);
        reset = 1'b1;
        @(negedge clk);
        chk("rc.tecla0", {8'h0, bus.tecla}, 16'h0);
        chk("rc.guardar0", {8'h0, bus.guardar}, 16'h0);
        chk_all("rc", 8'h0, 8'h0, 8'h0, 2'd0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rc.after", {8'h0, bus.tecla}, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/control_entrada_cronometro.md
Name: control_entrada_cronometro

Overview:
- Keyboard-entry controller that sits between the PS/2 scan-code receiver and the chronometer limit storage register.
- Assembles up to three decimal digits from set-2 make codes and supports backspace and escape.
- Handles break (F0) and E0-prefix bytes and suppresses typematic repeats.
- On the save key (0x75), emits the exact one-cycle store command the storage register expects (tecla=8'h75, guardar=8'h01) with the digits held stable. An idle timeout discards a stale entry.

Parameters:
- TIMEOUT_CYCLES, 500000000, cycles without an accepted scan byte in ENTRY before the entry is aborted (5 s at 100 MHz).
- TO_W, 29, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- scan_code  input  8  byte from the PS/2 receiver.
- scan_valid  input  1  one-cycle strobe, scan_code valid.
- dato1  output  8  hundreds digit, BCD in [3:0], [7:4]=0.
- dato2  output  8  tens digit, same format.
- dato3  output  8  units digit, same format.
- tecla  output  8  8'h75 during the commit cycle, else 8'h00.
- guardar  output  8  8'h01 during the commit cycle, else 8'h00.
- digit_count  output  2  digits entered, 0..3.
- entry_active  output  1  1 while in ENTRY.

Behaviour:
- Reset (sync, active-high, highest priority):
  - dato1/2/3=0, tecla=0, guardar=0, digit_count=0, entry_active=0.
  - State=IDLE; break_pending=0; last_code=8'h00; timeout counter=0.
- States: IDLE, ENTRY, COMMIT, CLEAR (binary encoded).
- Byte filtering applies in every state except COMMIT and CLEAR; bytes arriving in those states are dropped.
  - 8'hE0: ignored, no state change.
  - 8'hF0: sets break_pending.
  - Any byte while break_pending=1: clears break_pending and last_code, otherwise discarded.
  - Make code equal to last_code (typematic repeat): discarded.
  - Otherwise the make code is "accepted" and stored in last_code.
- Digit map (set 2): 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
- IDLE:
  - Accepted digit: dato3<=digit, dato2<=0, dato1<=0, digit_count<=1, go to ENTRY.
  - All other accepted codes are ignored.
- ENTRY (entry_active=1):
  - Digit with count<3: shift left; dato1<=dato2, dato2<=dato3, dato3<=digit; count+1.
  - Digit with count=3: ignored, but it still restarts the timeout.
  - 8'h66 backspace: dato3<=dato2, dato2<=dato1, dato1<=0; count-1. If count reaches 0, go to IDLE.
  - 8'h76 escape: clear digits, count=0, go to IDLE.
  - 8'h75 save (count>=1): go to COMMIT.
  - Other codes: ignored, but they restart the timeout.
- Timeout:
  - The counter clears on any scan_valid in ENTRY and increments otherwise.
  - At TIMEOUT_CYCLES-1: clear digits, count=0, counter=0, go to IDLE, no commit.
  - If scan_valid arrives in the same cycle as expiry, the scan byte wins and the counter restarts.
- COMMIT (exactly 1 cycle):
  - tecla=8'h75, guardar=8'h01, registered outputs.
  - dato1/2/3 and digit_count are held unchanged.
  - entry_active=0. Next state CLEAR.
- CLEAR (1 cycle):
  - tecla=0, guardar=0; dato1/2/3<=0, count<=0; go to IDLE.
- Latency: an accepted byte updates outputs on the clock edge after its scan_valid cycle. The save byte produces tecla/guardar on the following cycle.
- Reset asserted in any state, including COMMIT, returns everything to reset values on the next edge. No commit strobe is emitted after reset.

Test Plan:
- Reset: scan bytes 16 and 75 presented during reset -> all outputs 0, state IDLE after release.
- Normal entry: bytes 16,F0,16,1E,F0,1E,26,F0,26,75 -> dato1=01, dato2=02, dato3=03. Exactly one cycle with tecla=75 and guardar=01, digits stable in that cycle; next cycle digits=0, count=0.
- Repeat/overflow: bytes 16,16,16 (no break) -> count=1. Then F0,16,1E,F0,1E,26,F0,26,2E -> digits 1,2,3, 2E ignored, count=3.
- Backspace/escape: enter 4,5 then byte 66 -> dato3=04, count=1. Byte 76 -> IDLE, all 0. Save byte 75 in IDLE -> no tecla/guardar pulse.
- Timeout (TIMEOUT_CYCLES=20): enter digit 7, no bytes for 20 cycles -> entry aborted, digits=0, no commit. A byte arriving on cycle 19 restarts the count.
- Reset mid-commit: assert reset in the COMMIT cycle -> tecla=00 and guardar=00 on the next edge, digits=0.
